// File: rtl/reg_univ_pkg.sv
// Shared types for the universal register: operation encoding and its width.
package reg_univ_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ModeHold = 3'd0,
        ModeLoad = 3'd1,
        ModeShl  = 3'd2,
        ModeShr  = 3'd3,
        ModeRol  = 3'd4,
        ModeRor  = 3'd5,
        ModeAsr  = 3'd6,
        ModeClr  = 3'd7
    } mode_e;

endpackage

// File: rtl/reg_univ_next.sv
// Combinational next-state logic for reg_univ: computes the post-operation register value and the
// bit shifted or rotated out. ModeHold returns the current value; the caller decides whether
// Cout is updated.
module reg_univ_next
    import reg_univ_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             cout_next_o
);

    // Decode the operation into the new contents and the outgoing bit
    always_comb begin
        q_next_o    = q_i;
        cout_next_o = 1'b0;
        unique case (mode_i)
            ModeHold: begin
                q_next_o    = q_i;
                cout_next_o = 1'b0;
            end
            ModeLoad: begin
                q_next_o    = d_i;
                cout_next_o = 1'b0;
            end
            ModeShl: begin
                q_next_o    = {q_i[WIDTH-2:0], sin_i};
                cout_next_o = q_i[WIDTH-1];
            end
            ModeShr: begin
                q_next_o    = {sin_i, q_i[WIDTH-1:1]};
                cout_next_o = q_i[0];
            end
            ModeRol: begin
                q_next_o    = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                cout_next_o = q_i[WIDTH-1];
            end
            ModeRor: begin
                q_next_o    = {q_i[0], q_i[WIDTH-1:1]};
                cout_next_o = q_i[0];
            end
            ModeAsr: begin
                q_next_o    = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                cout_next_o = q_i[0];
            end
            ModeClr: begin
                q_next_o    = '0;
                cout_next_o = 1'b0;
            end
            default: begin
                q_next_o    = q_i;
                cout_next_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_univ.sv
// Universal register: WIDTH-bit accumulator/shift register with clock enable, eight modes,
// registered carry-out and combinational zero flag. Synchronous active-high reset.
// Optional shadow register (snap/restore/swap) enabled by defining REG_UNIV_SNAPSHOT_EN.
module reg_univ
    import reg_univ_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [MODE_W-1:0] Mode,
    input  logic [WIDTH-1:0]  D,
    input  logic              Sin,
    output logic [WIDTH-1:0]  Q,
    output logic              Cout,
    output logic              Zero
`ifdef REG_UNIV_SNAPSHOT_EN
    ,
    input  logic              Snap,
    input  logic              Restore,
    output logic [WIDTH-1:0]  Q_shadow
`endif
);

    if (WIDTH < 2) begin : g_width_check
        $error("reg_univ: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] q_next;
    logic             cout_next;
    mode_e            mode;

    assign mode = mode_e'(Mode);

    reg_univ_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q_i        (q_q),
        .d_i        (D),
        .sin_i      (Sin),
        .mode_i     (mode),
        .q_next_o   (q_next),
        .cout_next_o(cout_next)
    );

`ifdef REG_UNIV_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;

    // Enable gating, restore override and shadow capture (snap+restore swaps Q and shadow)
    always_comb begin
        q_d      = q_q;
        cout_d   = cout_q;
        shadow_d = shadow_q;
        if (En) begin
            if (Snap) begin
                shadow_d = q_q;
            end
            if (Restore) begin
                q_d    = shadow_q;
                cout_d = 1'b0;
            end else if (mode != ModeHold) begin
                q_d    = q_next;
                cout_d = cout_next;
            end
        end
    end

    // Shadow register, cleared by reset
    always_ff @(posedge clk) begin
        if (Rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign Q_shadow = shadow_q;
`else
    // Enable gating; ModeHold leaves both Q and Cout untouched
    always_comb begin
        q_d    = q_q;
        cout_d = cout_q;
        if (En && (mode != ModeHold)) begin
            q_d    = q_next;
            cout_d = cout_next;
        end
    end
`endif

    // Main register and carry-out flop; reset has priority over everything
    always_ff @(posedge clk) begin
        if (Rst) begin
            q_q    <= RST_VAL;
            cout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign Q    = q_q;
    assign Cout = cout_q;
    assign Zero = (q_q == '0);

endmodule

// File: tb/tb_reg_univ.sv
// Self-checking bench for reg_univ (WIDTH=4, RST_VAL=4'hA): directed vector table, hand-written
// reset/snapshot sequences, then random stimulus against an arithmetic reference model.
module tb_reg_univ;

    localparam int W = 4;
    localparam logic [3:0] RV = 4'hA;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sin;
    logic [3:0] q;
    logic       cout;
    logic       zero;
    logic       snap;
    logic       restore;
`ifdef REG_UNIV_SNAPSHOT_EN
    logic [3:0] q_shadow;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state (integers, arithmetic formulation)
    int m_q, m_c, m_s;

    reg_univ #(
        .WIDTH  (W),
        .RST_VAL(RV)
    ) dut (
        .clk     (clk),
        .Rst     (rst),
        .En      (en),
        .Mode    (mode),
        .D       (d),
        .Sin     (sin),
        .Q       (q),
        .Cout    (cout),
        .Zero    (zero)
`ifdef REG_UNIV_SNAPSHOT_EN
        ,
        .Snap    (snap),
        .Restore (restore),
        .Q_shadow(q_shadow)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [3:0] d;
        logic       sin;
        logic [3:0] exp_q;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m, input logic [3:0] dv,
                         input logic s);
        rst  = r;
        en   = e;
        mode = m;
        d    = dv;
        sin  = s;
    endtask

    // Reference: one clock edge computed from the operation definitions
    task automatic model_step();
        int nq, nc, ns;
        if (rst) begin
            m_q = int'(RV);
            m_c = 0;
            m_s = 0;
            return;
        end
        if (!en) return;
        nq = m_q;
        nc = m_c;
        ns = snap ? m_q : m_s;
        if (restore) begin
            nq = m_s;
            nc = 0;
        end else begin
            case (int'(mode))
                1: begin nq = int'(d); nc = 0; end
                2: begin nc = m_q / 8; nq = (m_q * 2) % 16 + int'(sin); end
                3: begin nc = m_q % 2; nq = m_q / 2 + int'(sin) * 8; end
                4: begin nc = m_q / 8; nq = (m_q * 2) % 16 + m_q / 8; end
                5: begin nc = m_q % 2; nq = m_q / 2 + (m_q % 2) * 8; end
                6: begin nc = m_q % 2; nq = m_q / 2 + (m_q / 8) * 8; end
                7: begin nc = 0; nq = 0; end
                default: ;
            endcase
        end
        m_q = nq;
        m_c = nc;
        m_s = ns;
    endtask

    initial begin
        snap    = 1'b0;
        restore = 1'b0;
        drive(1'b1, 1'b1, M_LOAD, 4'h3, 1'b0);

        // rst en mode d sin -> q cout zero
        vecs.push_back('{1'b1, 1'b1, M_LOAD, 4'h3, 1'b0, 4'hA, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_LOAD, 4'h3, 1'b0, 4'h3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_LOAD, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_SHL,  4'h0, 1'b1, 4'h3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_SHR,  4'h0, 1'b1, 4'h9, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ASR,  4'h0, 1'b0, 4'hC, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_LOAD, 4'h8, 1'b0, 4'h8, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ROL,  4'h0, 1'b0, 4'h1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ROL,  4'h0, 1'b0, 4'h2, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ROL,  4'h0, 1'b0, 4'h4, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ROL,  4'h0, 1'b0, 4'h8, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_LOAD, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_ROR,  4'h0, 1'b0, 4'h8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_HOLD, 4'h5, 1'b1, 4'h8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, M_LOAD, 4'h5, 1'b1, 4'h8, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_LOAD, 4'h6, 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, M_CLR,  4'h0, 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, M_CLR,  4'h0, 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, M_CLR,  4'h0, 1'b0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, M_CLR,  4'h0, 1'b0, 4'h0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
            step();
            chk($sformatf("vec%0d_q", i), {4'h0, q}, {4'h0, vecs[i].exp_q});
            chk($sformatf("vec%0d_cout", i), {7'h0, cout}, {7'h0, vecs[i].exp_c});
            chk($sformatf("vec%0d_zero", i), {7'h0, zero}, {7'h0, vecs[i].exp_z});
        end

        // Reset in the middle of a shift run; next shift starts from RST_VAL
        drive(1'b0, 1'b1, M_LOAD, 4'h5, 1'b0);
        step();
        drive(1'b0, 1'b1, M_SHL, 4'h0, 1'b0);
        step();
        chk("midrst_shl1_q", {4'h0, q}, 8'h0A);
        drive(1'b1, 1'b1, M_SHL, 4'h0, 1'b0);
        step();
        chk("midrst_rst_q", {4'h0, q}, 8'h0A);
        chk("midrst_rst_cout", {7'h0, cout}, 8'h00);
        drive(1'b0, 1'b1, M_SHL, 4'h0, 1'b0);
        step();
        chk("midrst_resume_q", {4'h0, q}, 8'h04);
        chk("midrst_resume_cout", {7'h0, cout}, 8'h01);

`ifdef REG_UNIV_SNAPSHOT_EN
        // Snap during clear, restore, then snap+restore swap
        drive(1'b0, 1'b1, M_LOAD, 4'h5, 1'b0);
        step();
        snap = 1'b1;
        drive(1'b0, 1'b1, M_CLR, 4'h0, 1'b0);
        step();
        snap = 1'b0;
        chk("snap_q", {4'h0, q}, 8'h00);
        chk("snap_shadow", {4'h0, q_shadow}, 8'h05);
        restore = 1'b1;
        drive(1'b0, 1'b1, M_SHL, 4'h0, 1'b1);
        step();
        restore = 1'b0;
        chk("restore_q", {4'h0, q}, 8'h05);
        chk("restore_cout", {7'h0, cout}, 8'h00);
        drive(1'b0, 1'b1, M_LOAD, 4'hF, 1'b0);
        step();
        snap    = 1'b1;
        restore = 1'b1;
        drive(1'b0, 1'b1, M_HOLD, 4'h0, 1'b0);
        step();
        snap    = 1'b0;
        restore = 1'b0;
        chk("swap_q", {4'h0, q}, 8'h05);
        chk("swap_shadow", {4'h0, q_shadow}, 8'h0F);
        drive(1'b1, 1'b1, M_HOLD, 4'h0, 1'b0);
        step();
        chk("rst_shadow", {4'h0, q_shadow}, 8'h00);
`endif

        // Random stimulus against the reference model, starting from a known reset
        drive(1'b1, 1'b1, M_HOLD, 4'h0, 1'b0);
        model_step();
        step();
        chk("rand_init_q", {4'h0, q}, 8'(m_q));
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            d    = 4'($urandom_range(0, 15));
            sin  = 1'($urandom_range(0, 1));
`ifdef REG_UNIV_SNAPSHOT_EN
            snap    = ($urandom_range(0, 5) == 0);
            restore = ($urandom_range(0, 7) == 0);
`endif
            model_step();
            step();
            chk($sformatf("rand%0d_q", i), {4'h0, q}, 8'(m_q));
            chk($sformatf("rand%0d_cout", i), {7'h0, cout}, 8'(m_c));
            chk($sformatf("rand%0d_zero", i), {7'h0, zero}, (m_q == 0) ? 8'h01 : 8'h00);
`ifdef REG_UNIV_SNAPSHOT_EN
            chk($sformatf("rand%0d_shadow", i), {4'h0, q_shadow}, 8'(m_s));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
